ysyx_24120013_fetch_ctrl: RTL and testbench
===========================================

# ysyx_24120013_fetch_ctrl

Instruction-fetch controller that owns the program counter, issues single-beat reads to instruction memory over a valid/ready request and valid response channel, and hands each fetched instruction to the decode stage (IDU) over a valid/ready handshake. It sits directly upstream of the IDU and replaces the bare PC register plus pass-through fetch path. It accepts PC redirects from the execute stage and discards wrong-path fetches.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- XLEN, 32, address/instruction width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_resp_valid  in  1  read data valid, one pulse per accepted request
- imem_resp_data  in  XLEN  instruction word
- imem_resp_err  in  1  access fault, qualified by imem_resp_valid
- inst_valid  out  1  instruction available to IDU
- inst_ready  in  1  IDU accepts instruction
- inst  out  XLEN  instruction word to IDU
- inst_pc  out  XLEN  address of inst
- redirect_en  in  1  execute-stage redirect request
- redirect_pc  in  XLEN  redirect target
- fetch_fault  out  1  sticky fetch error flag
- pc  out  XLEN  next address to fetch

## Operation
- Reset (async, immediate): state IDLE, pc=RESET_PC, drop=0, inst=0, inst_pc=0; all valid outputs and fetch_fault 0.
- States: IDLE, REQ, WAIT, HOLD, FAULT. Outputs decoded from registered state: imem_req_valid=(REQ), inst_valid=(HOLD), fetch_fault=(FAULT). imem_req_addr=pc.
- IDLE -> REQ unconditionally.
- REQ: on imem_req_ready -> WAIT. redirect_en in REQ: pc<=redirect_pc; if imem_req_ready same cycle, drop<=1 (old-address request already issued).
- WAIT: on imem_resp_valid:
  - drop=1 or redirect_en same cycle: discard data, drop<=0, -> REQ.
  - else imem_resp_err=1: -> FAULT.
  - else inst<=imem_resp_data, inst_pc<=pc, pc<=pc+4, -> HOLD.
- redirect_en in WAIT without response: pc<=redirect_pc, drop<=1, stay WAIT.
- HOLD: inst_ready=1 -> REQ. redirect_en: held instruction is wrong-path; pc<=redirect_pc, -> REQ; a transfer coinciding with redirect_en is not counted and the IDU squashes it.
- FAULT: terminal; no requests, redirect ignored; leave only via rst.
- Redirect bits [1:0] are forced to 0; pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- imem_resp_valid outside WAIT is ignored (covers stale responses after reset).
- Exactly one request outstanding at any time.

## Timing
- inst, inst_pc, and pc stable while inst_valid=1 and no redirect.
- imem_req_addr changes while imem_req_valid=1 only on redirect; memory must sample the address at handshake.
- Best case (ready and response each one cycle later): REQ c1, WAIT c2 (resp), HOLD c3. Steady throughput is 1 instruction per 3 cycles.
- First request asserts 1 cycle after rst deasserts.
- Redirect-to-request latency: 1 cycle from REQ/HOLD; from WAIT, 1 cycle after the pending response arrives.

## Structure
- Shared package ysyx_24120013_fetch_pkg: state enum (IDLE, REQ, WAIT, HOLD, FAULT), RESET_PC default, XLEN, INST_NOP=32'h0000_0013.
- Single module for the FSM. The next-pc mux (reset / +4 / redirect, alignment masking) is a natural sub-module: ysyx_24120013_fetch_pcgen.

## Test plan
- Reset release, memory always ready, 1-cycle response with data 32'h0010_0093 -> request addr 32'h8000_0000 at c1; inst_valid at c3 with inst_pc=32'h8000_0000; next request addr 32'h8000_0004.
- IDU holds inst_ready=0 for 5 cycles -> inst/inst_pc stable, no new request; accept -> REQ next cycle.
- redirect_en with redirect_pc=32'h8000_0103 during WAIT -> old response discarded, inst_valid stays 0, next request addr 32'h8000_0100.
- Response with imem_resp_err=1 -> fetch_fault=1 the next cycle and permanently; no further requests; redirect ignored; rst clears it.
- rst asserted in WAIT, then late imem_resp_valid -> response ignored; fetch restarts at 32'h8000_0000.
- pc=32'hFFFF_FFFC fetch completes -> pc wraps to 32'h0000_0000.

Source files
------------

// File: rtl/ysyx_24120013_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_fetch_pkg
// Shared definitions for the instruction-fetch controller:
//   XLEN      - address / instruction width
//   RESET_PC  - program counter value after reset
//   INST_NOP  - canonical RISC-V nop (addi x0, x0, 0)
//   fetch_state_e - fetch FSM states
//   pc_sel_e      - next-pc source select for the pc generator
// ---------------------------------------------------------------------------
package ysyx_24120013_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/ysyx_24120013_fetch_pcgen.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_fetch_pcgen
// Combinational next-pc mux. The reset value lives in the pc register itself;
// this block only chooses between holding, sequential +4 and a redirect.
//   pc_i          - current pc
//   sel_i         - PC_KEEP / PC_INC / PC_REDIR
//   redirect_pc_i - redirect target (low two bits are discarded)
//   pc_next_o     - next pc
// ---------------------------------------------------------------------------
module ysyx_24120013_fetch_pcgen
  import ysyx_24120013_fetch_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] pc_i,
  input  pc_sel_e      sel_i,
  input  logic [W-1:0] redirect_pc_i,
  output logic [W-1:0] pc_next_o
);

  // Low bits of the target are forced to zero, so they are never read.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      PC_INC:   pc_next_o = pc_i + W'(4);  // wraps modulo 2^W
      PC_REDIR: pc_next_o = {redirect_pc_i[W-1:2], 2'b00};
      default:  pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/ysyx_24120013_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_fetch_ctrl
// Instruction-fetch controller: owns the pc, issues one read at a time to
// instruction memory and presents each fetched word to the decode stage.
//
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       - memory read request
//   imem_resp_valid/data/err        - memory read response (one per request)
//   inst_valid/ready, inst, inst_pc - instruction handoff to decode
//   redirect_en, redirect_pc        - execute-stage pc redirect
//   fetch_fault                     - sticky access-fault flag
//   pc                              - next address to fetch
//   dbg_state                       - current FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid depends only on registered state, never on ready. The
// request address may change while valid is high only on a redirect, so the
// memory must sample it at the handshake edge. imem_resp_valid is a single
// pulse per accepted request and has no ready; it is ignored outside WAIT.
// ---------------------------------------------------------------------------
module ysyx_24120013_fetch_ctrl
  import ysyx_24120013_fetch_pkg::*;
#(
  parameter int              XLEN     = ysyx_24120013_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = ysyx_24120013_fetch_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] pc,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  // drop_q marks the outstanding request as wrong-path: its response must
  // be consumed (to keep one request in flight) but not delivered.
  logic            drop_q, drop_d;
  pc_sel_e         pc_sel;

  ysyx_24120013_fetch_pcgen #(.W(XLEN)) u_pcgen (
    .pc_i          (pc_q),
    .sel_i         (pc_sel),
    .redirect_pc_i (redirect_pc),
    .pc_next_o     (pc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    pc_sel    = PC_KEEP;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
        if (redirect_en) begin
          pc_sel = PC_REDIR;
          // The old address was already handed to memory this edge.
          if (imem_req_ready) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_en) pc_sel = PC_REDIR;
        if (imem_resp_valid) begin
          if (drop_q || redirect_en) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (imem_resp_err) begin
            state_d = FAULT;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            pc_sel    = PC_INC;
            state_d   = HOLD;
          end
        end else if (redirect_en) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        // A redirect squashes the held word even if decode takes it.
        if (redirect_en) begin
          pc_sel  = PC_REDIR;
          state_d = REQ;
        end else if (inst_ready) begin
          state_d = REQ;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = (state_q == FAULT);
  assign pc             = pc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_24120013_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24120013_fetch_ctrl
// Directed scenarios followed by a randomized run. A memory model returns
// mem_word(addr) for each accepted request; a program-order model tracks the
// address the next delivered instruction must carry.
// ---------------------------------------------------------------------------
module tb_ysyx_24120013_fetch_ctrl;
  import ysyx_24120013_fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] pc;
  fetch_state_e dbg_state;

  ysyx_24120013_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .fetch_fault     (fetch_fault),
    .pc              (pc),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];        // addresses accepted by memory, not yet answered
  int          resp_cnt = 0;
  int          resp_delay = 0;
  bit          mem_rand = 0, rand_mode = 0, err_next = 0, stale = 0;
  bit          drv_rst = 1, drv_inst_ready = 0, drv_redirect = 0;
  logic [31:0] drv_redirect_pc = '0;
  logic [31:0] exp_pc = 32'h8000_0000;
  int          n_req = 0, n_deliv = 0;
  int          snap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8010_0093;   // 0x8000_0000 -> 0x0010_0093
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Runs at the falling edge: observes settled outputs, then drives the
  // inputs that the next rising edge will sample, and updates the models.
  task automatic cycle();
    logic [31:0] a;
    @(negedge clk);
    rst = drv_rst;
    if (drv_rst) begin
      exp_pc = 32'h8000_0000;
      if (exp_q.size() != 0) stale = 1;
    end
    // memory response side; junk on data/err when not valid
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    imem_resp_err   = 1'($urandom_range(0, 1));
    if (exp_q.size() != 0) begin
      if (resp_cnt == 0) begin
        a = exp_q.pop_front();
        imem_resp_valid = 1'b1;
        if (stale) begin
          imem_resp_data = 32'hDEAD_BEEF;
          imem_resp_err  = 1'b1;
          stale = 0;
        end else begin
          imem_resp_data = mem_word(a);
          imem_resp_err  = err_next;
          err_next = 0;
        end
      end else begin
        resp_cnt--;
      end
    end
    // memory request side
    imem_req_ready = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!rst && imem_req_valid && imem_req_ready) begin
      check("one_outstanding", 32'(exp_q.size()), 32'd0);
      check("req_addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
      exp_q.push_back(imem_req_addr);
      n_req++;
      resp_cnt = mem_rand ? int'($urandom_range(0, 3)) : resp_delay;
    end
    // decode / execute side
    if (rand_mode) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect_en = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
    end else begin
      inst_ready  = drv_inst_ready;
      redirect_en = drv_redirect;
      redirect_pc = drv_redirect_pc;
    end
    // program-order model
    if (!rst) begin
      if (redirect_en) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (inst_valid && inst_ready) begin
        check("deliver_pc", inst_pc, exp_pc);
        check("deliver_data", inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end
  endtask

  task automatic do_reset();
    drv_rst = 1; drv_redirect = 0; drv_inst_ready = 0;
    cycle();
    cycle();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    drv_rst = 0;
    cycle();
  endtask

  task automatic wait_inst(input int budget, input string tag);
    int n = 0;
    while (!inst_valid && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n = 0;
    while (!imem_req_valid && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, {31'd0, imem_req_valid}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0;   imem_resp_err = 1'b0;
    inst_ready = 1'b0;     redirect_en = 1'b0; redirect_pc = '0;

    // best-case fetch after reset
    do_reset();
    check("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    check("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("c1_req_addr", imem_req_addr, 32'h8000_0000);
    cycle();
    check("c2_no_inst", {31'd0, inst_valid}, 32'd0);
    check("c2_no_req", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    check("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("c3_inst", inst, 32'h0010_0093);
    check("c3_inst_pc", inst_pc, 32'h8000_0000);
    check("c3_pc", pc, 32'h8000_0004);

    // decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_inst", inst, 32'h0010_0093);
      check("stall_inst_pc", inst_pc, 32'h8000_0000);
      check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    drv_inst_ready = 1;
    cycle();
    drv_inst_ready = 0;
    resp_delay = 2;
    cycle();
    check("accept_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("accept_req_addr", imem_req_addr, 32'h8000_0004);

    // redirect while waiting for a response
    drv_redirect = 1; drv_redirect_pc = 32'h8000_0103;
    cycle();
    drv_redirect = 0;
    cycle();
    check("wredir_pc", pc, 32'h8000_0100);
    check("wredir_no_inst", {31'd0, inst_valid}, 32'd0);
    check("wredir_no_req", {31'd0, imem_req_valid}, 32'd0);
    resp_delay = 0;
    cycle();
    check("wredir_discard", {31'd0, inst_valid}, 32'd0);
    cycle();
    check("wredir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("wredir_req_addr", imem_req_addr, 32'h8000_0100);
    check("wredir_still_no_inst", {31'd0, inst_valid}, 32'd0);
    wait_inst(20, "wredir_inst");
    check("wredir_inst_pc", inst_pc, 32'h8000_0100);
    check("wredir_inst", inst, mem_word(32'h8000_0100));
    drv_inst_ready = 1;
    cycle();
    drv_inst_ready = 0;

    // access fault is terminal until reset
    do_reset();
    err_next = 1;
    cycle();
    cycle();
    check("fault_not_yet", {31'd0, fetch_fault}, 32'd0);
    cycle();
    check("fault_set", {31'd0, fetch_fault}, 32'd1);
    check("fault_no_inst", {31'd0, inst_valid}, 32'd0);
    snap = n_req;
    drv_redirect = 1; drv_redirect_pc = 32'h8000_0200;
    cycle();
    drv_redirect = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      check("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    check("fault_req_count", 32'(n_req), 32'(snap));

    // reset while waiting, stale response arrives afterwards
    do_reset();
    check("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    resp_delay = 2;
    cycle();
    resp_delay = 0;
    drv_rst = 1;
    cycle();
    drv_rst = 0;
    cycle();
    check("wrst_idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    check("wrst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("wrst_req_addr", imem_req_addr, 32'h8000_0000);
    cycle();
    check("wrst_stale_ignored", {31'd0, fetch_fault}, 32'd0);
    check("wrst_no_inst", {31'd0, inst_valid}, 32'd0);
    cycle();
    check("wrst_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("wrst_inst", inst, 32'h0010_0093);
    check("wrst_inst_pc", inst_pc, 32'h8000_0000);
    drv_inst_ready = 1;
    cycle();
    drv_inst_ready = 0;

    // pc wrap at the top of the address space (target low bits masked)
    do_reset();
    drv_redirect = 1; drv_redirect_pc = 32'hFFFF_FFFE;
    cycle();
    drv_redirect = 0;
    wait_inst(30, "wrap_inst");
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_inst", inst, mem_word(32'hFFFF_FFFC));
    check("wrap_pc", pc, 32'h0000_0000);
    drv_inst_ready = 1;
    cycle();
    drv_inst_ready = 0;
    wait_req(10, "wrap_req");
    check("wrap_req_addr", imem_req_addr, 32'h0000_0000);

    // randomized traffic: memory stalls, decode stalls, redirects
    do_reset();
    cycle();
    snap = n_deliv;
    mem_rand = 1; rand_mode = 1;
    repeat (3000) cycle();
    mem_rand = 0; rand_mode = 0;
    check("random_progress", {31'd0, (n_deliv - snap) >= 100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
